button_conditioner: RTL and testbench

- Input-side front end for the elevator controller; the counterpart of the LED output path.
- Takes the four raw, asynchronous push-button lines (GUPB, GLPB, CUPB, CLPB). Synchronises and debounces each one.
- Emits a clean level, a single-cycle press pulse and a sticky request bit per button. Each request bit holds until the controller clears it on service.
- Sits between the board pins and the transducers/control logic, in the clk domain.

---
 rtl/elevator_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 104 ++++++++++
 rtl/button_conditioner.sv | 45 ++++
 tb/tb_button_conditioner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller front end.
//   - button index constants (bit positions in every N_BTN-wide bus)
//   - default channel count and debounce length
//   - debounce FSM state encoding
package elevator_pkg;

  localparam int BTN_GU = 0;
  localparam int BTN_GL = 1;
  localparam int BTN_CU = 2;
  localparam int BTN_CL = 3;

  localparam int N_BTN_DEFAULT           = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;  // 5 ms at 50 MHz
  localparam int CNT_W_DEFAULT           = 18;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit button conditioner: 2-flop synchronizer, debounce counter and
// four-state FSM producing a clean level and a one-cycle press pulse.
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   raw    in   asynchronous button pin (may bounce)
//   level  out  debounced level (registered)
//   press  out  one-cycle pulse on accepted 0->1 (registered)
module debounce_channel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt;

  // Plain flop chain; nothing may sit between the two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
    end
  end

  // The count includes the cycle that left the stable state, so the new
  // value is accepted after DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    press_nxt = 1'b0;
    case (state)
      S_LOW: begin
        if (sync2) begin
          state_nxt = S_RISE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_RISE: begin
        if (!sync2) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          state_nxt = S_FALL;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_FALL: begin
        if (sync2) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: one debounce channel per button plus a sticky
// request latch that holds each accepted press until control services it.
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   btn_raw    in   [N_BTN] raw pins (GU=0, GL=1, CU=2, CL=3)
//   clr        in   [N_BTN] request clear from control
//   btn_level  out  [N_BTN] debounced level
//   btn_press  out  [N_BTN] one-cycle pulse per accepted press
//   req        out  [N_BTN] latched pending request
module button_conditioner
  import elevator_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] req
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[g]),
      .level(btn_level[g]),
      .press(btn_press[g])
    );
  end

  // Set has priority over clear so a call arriving during service survives.
  always_ff @(posedge clk) begin
    if (reset) req <= '0;
    else       req <= btn_press | (req & ~clr);
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  import elevator_pkg::*;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw, clr, btn_level, btn_press, req;

  int            n_chk = 0;
  int            n_err = 0;
  int            press_cnt[NB];
  logic          dbl = 1'b0;
  logic [NB-1:0] prev_press = '0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .clr      (clr),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .req      (req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) press_cnt[i] = 0;
  endtask

  // Advance one edge and sample 1 ns later; tally pulses and flag any
  // pulse that lasts two cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) if (btn_press[i] === 1'b1) press_cnt[i]++;
    if ((btn_press & prev_press) !== '0) dbl = 1'b1;
    prev_press = btn_press;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic [0:5] seq;
    clear_counts();
    reset   = 1'b1;
    btn_raw = 4'b1111;
    clr     = '0;

    // 1. reset holds everything at 0 even with buttons pressed
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_outs", 32'({btn_level, btn_press, req}), 32'h0);
    end
    reset = 1'b0;
    clear_counts();
    run(5);
    check("rst_lvl_e4", 32'(btn_level), 32'h0);
    tick();
    check("rst_lvl_e5", 32'(btn_level), 32'hf);
    check("rst_prs_e5", 32'(btn_press), 32'hf);
    tick();
    check("rst_prs_e6", 32'(btn_press), 32'h0);
    check("rst_req_e6", 32'(req), 32'hf);
    btn_raw = '0;
    clr     = 4'b1111;
    clear_counts();
    tick();
    check("clr_all", 32'(req), 32'h0);
    clr = '0;
    run(7);
    check("rel_lvl", 32'(btn_level), 32'h0);
    check("rel_nopulse", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

    // 2. clean press on GU
    clear_counts();
    btn_raw[BTN_GU] = 1'b1;
    run(5);
    check("gu_prs_e4", 32'(btn_press), 32'h0);
    tick();
    check("gu_prs_e5", 32'(btn_press), 32'h1);
    check("gu_lvl_e5", 32'(btn_level), 32'h1);
    tick();
    check("gu_req", 32'(req), 32'h1);
    check("gu_prs_e6", 32'(btn_press), 32'h0);
    run(18);
    check("gu_hold_cnt", 32'(press_cnt[BTN_GU]), 32'd1);
    check("gu_hold_lvl", 32'(btn_level), 32'h1);
    btn_raw = '0;
    run(8);
    check("gu_rel_lvl", 32'(btn_level), 32'h0);
    check("gu_rel_cnt", 32'(press_cnt[BTN_GU]), 32'd1);
    check("gu_req_held", 32'(req), 32'h1);
    clr = 4'b0001;
    tick();
    check("gu_clr", 32'(req), 32'h0);
    clr = '0;

    // 3. bounce rejection on CU
    clear_counts();
    seq = 6'b101101;
    for (int k = 0; k < 6; k++) begin
      btn_raw[BTN_CU] = seq[k];
      tick();
    end
    check("cu_bnc_cnt", 32'(press_cnt[BTN_CU]), 32'd0);
    check("cu_bnc_lvl", 32'(btn_level[BTN_CU]), 32'd0);
    run(4);
    check("cu_lvl_e10", 32'(btn_level[BTN_CU]), 32'd0);
    run(2);
    check("cu_hold_cnt", 32'(press_cnt[BTN_CU]), 32'd1);
    check("cu_hold_lvl", 32'(btn_level), 32'h4);
    btn_raw = '0;
    run(8);
    clr = 4'b0100;
    tick();
    clr = '0;
    check("cu_clr", 32'(req), 32'h0);

    // 4. clear vs press on GL
    btn_raw[BTN_GL] = 1'b1;
    run(6);
    check("gl_prs", 32'(btn_press), 32'h2);
    tick();
    check("gl_req", 32'(req), 32'h2);
    clr = 4'b0010;
    tick();
    check("gl_clr", 32'(req), 32'h0);
    clr = '0;
    btn_raw = '0;
    run(8);
    btn_raw[BTN_GL] = 1'b1;
    run(6);
    check("gl_prs2", 32'(btn_press), 32'h2);
    clr = 4'b1010;  // CL has no request: clear must be harmless there
    tick();
    check("gl_set_wins", 32'(req), 32'h2);
    clr = '0;
    tick();
    check("gl_req_stay", 32'(req), 32'h2);
    btn_raw = '0;
    run(8);
    clr = 4'b1111;
    tick();
    clr = '0;
    check("gl_clr_all", 32'(req), 32'h0);

    // 5. simultaneous GL + CL
    clear_counts();
    btn_raw = 4'b1010;
    run(6);
    check("sim_prs", 32'(btn_press), 32'ha);
    check("sim_lvl", 32'(btn_level), 32'ha);
    tick();
    check("sim_prs_off", 32'(btn_press), 32'h0);
    check("sim_req", 32'(req), 32'ha);
    check("sim_others", 32'(press_cnt[BTN_GU] + press_cnt[BTN_CU]), 32'd0);

    // 6. reset mid-debounce (GL) and mid-hold (CL)
    btn_raw = 4'b1000;
    run(8);
    check("mid_lvl", 32'(btn_level), 32'h8);
    btn_raw = 4'b1010;
    run(4);  // GL now in S_RISE with cnt=2
    reset = 1'b1;
    tick();
    check("mid_rst_outs", 32'({btn_level, btn_press, req}), 32'h0);
    reset = 1'b0;
    run(5);
    check("mid_prs_e4", 32'(btn_press), 32'h0);
    tick();
    check("mid_prs_e5", 32'(btn_press), 32'ha);
    check("mid_lvl_e5", 32'(btn_level), 32'ha);
    tick();
    check("no_double_pulse", 32'(dbl), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
